// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and port-slice helper for regfile_mp
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_DEPTH = 32;

  // Bit offset of port `port` inside a flattened bus of `width`-bit fields.
  function automatic int unsigned port_off(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - clear sequencer: zeroes entries 1..DEPTH-1, one per cycle
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_ready,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          sb_clr_all
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_en     = 1'b0;
    sb_clr_all = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          idx_d      = AW'(1);
          sb_clr_all = 1'b1;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        // Index stops at the last entry; it never wraps back to 0.
        if (idx_q == LAST) state_d = DONE;
        else               idx_d   = idx_q + AW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q != IDLE);
  assign clr_done = (state_q == DONE);
  assign wr_ready = ~clr_busy;
  assign clr_addr = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with pending-write scoreboard and clear sequencer
// Optional same-cycle write-through forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = DEF_XLEN,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_pend,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  output logic                  wr_ready,
  input  logic                  iss_v,
  input  logic [AW-1:0]         iss_a,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] sb_q, sb_d;

  logic          clr_en;
  logic [AW-1:0] clr_addr;
  logic          sb_clr_all;
  logic          wr_commit;
  logic          iss_ok;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .wr_ready   (wr_ready),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr),
    .sb_clr_all (sb_clr_all)
  );

  assign wr_commit = we && wr_ready && (wa != '0);
  assign iss_ok    = iss_v && (iss_a != '0) && !clr_busy;

  always_comb begin
    mem_d = mem_q;
    if (wr_commit) mem_d[wa] = wd;
    if (clr_en)    mem_d[clr_addr] = '0;
    mem_d[0] = '0;
  end

  // Issue is applied after the write clear so a same-cycle issue wins.
  always_comb begin
    sb_d = sb_q;
    if (sb_clr_all) begin
      sb_d = '0;
    end else begin
      if (wr_commit) sb_d[wa]    = 1'b0;
      if (iss_ok)    sb_d[iss_a] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      sb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      sb_q  <= sb_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a = ra[port_off(g, AW) +: AW];
`ifdef REGFILE_MP_BYPASS_EN
    assign hit = wr_commit && (a == wa);
`else
    assign hit = 1'b0;
`endif
    assign rd_data[port_off(g, XLEN) +: XLEN] = hit ? wd : mem_q[a];
    assign rd_pend[g] = hit ? 1'b0 : sb_q[a];
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file; the successor to the current fixed 32x32, 2-read-port file in the RISC-V datapath. It adds:
- configurable width, depth and read-port count;
- a per-register pending-write scoreboard for pipelined hazard detection;
- a hardware clear sequencer that zeroes the array one entry per cycle.
Sits between decode (reads, issue marking) and writeback.

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of registers; power of two, >= 4; entry 0 hard-wired to zero
NREAD, 2, number of independent read ports, 1..4
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
ra  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_pend  out  NREAD  scoreboard bit of the addressed register, per port
we  in  1  write request
wa  in  AW  write address
wd  in  XLEN  write data
wr_ready  out  1  write port accepts; write commits only when we && wr_ready
iss_v  in  1  mark iss_a pending (instruction issued with this rd)
iss_a  in  AW  register to mark pending
clr_req  in  1  start clear sequence (pulse or level)
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse at end of clear

Behaviour:
- Reset (rst=1 at posedge):
  - all entries 0; scoreboard all 0;
  - FSM to IDLE; clr_busy=0, clr_done=0, wr_ready=1.
- Reads are combinational (0-cycle latency).
  - ra=0 returns 0 and rd_pend=0 regardless of any write or issue to 0.
- Writes commit at posedge when we && wr_ready && wa!=0.
  - Visible on rd_data from the following cycle (see optional feature for same-cycle).
  - A committed write clears the scoreboard bit of wa.
- Issue: iss_v && iss_a!=0 && !clr_busy sets the scoreboard bit of iss_a at posedge.
  - Same-cycle write and issue to the same address: set wins, bit ends at 1.
  - Issue to 0 is ignored.
  - Issue during clr_busy is dropped.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, index<=1, whole scoreboard zeroed at the same edge.
  - CLEAR: entry[index]<=0 each cycle, index++. At index==DEPTH-1, write that entry then -> DONE. This gives DEPTH-1 cycles in CLEAR.
  - DONE: clr_done=1 for exactly this cycle -> IDLE.
  - clr_busy=1 in CLEAR and DONE; wr_ready=!clr_busy.
  - clr_req while busy is ignored; clr_req held high re-triggers only after returning to IDLE.
  - we while wr_ready=0 is not committed; the producer must hold it.
  - Reads stay valid during clear: already-cleared entries read 0, others read the old value.
- rst mid-clear aborts to IDLE with the full reset values; no clr_done pulse.
- Index counter is AW bits and never wraps past DEPTH-1.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: when we && wr_ready && wa!=0 && ra[i]==wa, rd_data[i]=wd and rd_pend[i]=0 in the same cycle (write-through forwarding). If iss_v to the same address is also asserted, rd_pend[i] still shows 0 this cycle.
- Undefined: reads return the stored value; the new value appears next cycle.

Decomposition:
- Package regfile_pkg:
  - clear-state enum (IDLE, CLEAR, DONE), 2-bit typedef;
  - default XLEN/DEPTH constants;
  - helper function for the per-port slice offset.
- One sub-module, regfile_clr_seq: clear FSM, index counter, clr_busy/clr_done/wr_ready. Outputs a clear-enable and clear-address into the array write logic.
- Read muxes and scoreboard stay in the top.

Test Plan:
- Reset then write 0xDEADBEEF to r5, read ra0=5 next cycle -> rd_data0=0xDEADBEEF. Write 0x1234 to r0 -> ra1=0 reads 0.
- iss_v with iss_a=7 -> rd_pend=1 on ports addressing 7. Write to r7 -> rd_pend=0 next cycle. Same-cycle write r7 plus iss r7 -> rd_pend stays 1.
- Fill r1..r31 with their index value, pulse clr_req:
  - clr_busy=1 for exactly 32 cycles (31 CLEAR + DONE);
  - clr_done pulses once;
  - all reads 0 afterwards;
  - we held during busy commits on the first cycle wr_ready=1.
- Assert rst at clear cycle 10:
  - next cycle clr_busy=0, wr_ready=1, all entries 0;
  - no clr_done pulse.
- With REGFILE_MP_BYPASS_EN: write 0xA5A5A5A5 to r3 while ra0=3 -> rd_data0=0xA5A5A5A5 the same cycle. Without the macro -> old value that cycle, new value next cycle.
- NREAD=4, DEPTH=16, XLEN=64: four ports reading distinct and identical addresses concurrently return the correct values; address 15 is the last one cleared.
